// File: rtl/cl_serial_drv_pkg.sv
// Shared encodings for the bit-serial driver of the 1-bit cl logic unit.
// cl_eval is the reference behaviour of cl for callers and models.
package cl_serial_drv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  function automatic logic cl_eval(input logic a, input logic b, input logic [1:0] s);
    case (s)
      OP_AND:  cl_eval = a & b;
      OP_OR:   cl_eval = a | b;
      OP_XOR:  cl_eval = a ^ b;
      default: cl_eval = ~a;
    endcase
  endfunction

endpackage

// File: rtl/cl_serial_drv_shift_reg.sv
// Right-shift register with parallel load and serial-in at the MSB.
// Load wins over shift; everything clears on reset.
module cl_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/cl_serial_drv.sv
// Feeds one operand bit pair per clock into a single cl unit, LSB first,
// and collects its output into a WIDTH-bit result.
module cl_serial_drv
  import cl_serial_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             cl_a,
  output logic             cl_b,
  output logic [1:0]       cl_s,
  input  logic             cl_out,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             accept, shift_en;
  logic             unused_bits;

  assign unused_bits = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    cl_a      = 1'b0;
    cl_b      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        cl_a     = a_sh[0];
        cl_b     = b_sh[0];
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        // A start here is taken immediately so ops can run back-to-back.
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_r  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt  <= '0;
        op_r <= op_in;
      end else if (shift_en && cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign cl_s = op_r;

  cl_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .reset(reset), .load(accept), .shift(shift_en),
    .sin(1'b0), .load_val(a_in), .q(a_sh)
  );

  cl_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .reset(reset), .load(accept), .shift(shift_en),
    .sin(1'b0), .load_val(b_in), .q(b_sh)
  );

  // The result fills from the MSB end so bit i lands in place after WIDTH shifts.
  cl_shift_reg #(.WIDTH(WIDTH)) u_result (
    .clk(clk), .reset(reset), .load(accept), .shift(shift_en),
    .sin(cl_out), .load_val({WIDTH{1'b0}}), .q(result)
  );

endmodule

// File: tb/tb_cl_serial_drv.sv
// Directed bench for cl_serial_drv at WIDTH=8, plus WIDTH=2/32 latency instances.
module tb_cl_serial_drv;
  import cl_serial_drv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, ready, cl_a, cl_b, cl_out, done;
  logic [1:0] op_in, cl_s;
  logic [7:0] a_in, b_in, result;

  logic        start2, ready2, cl_a2, cl_b2, cl_out2, done2;
  logic [1:0]  op2, cl_s2, a2, b2, result2;
  logic        start32, ready32, cl_a32, cl_b32, cl_out32, done32;
  logic [1:0]  op32, cl_s32;
  logic [31:0] a32, b32, result32;

  int checks = 0;
  int errors = 0;
  int n;

  cl_serial_drv #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .ready(ready), .cl_a(cl_a), .cl_b(cl_b), .cl_s(cl_s), .cl_out(cl_out),
    .result(result), .done(done)
  );
  assign cl_out = cl_eval(cl_a, cl_b, cl_s);

  cl_serial_drv #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .op_in(op2), .a_in(a2), .b_in(b2),
    .ready(ready2), .cl_a(cl_a2), .cl_b(cl_b2), .cl_s(cl_s2), .cl_out(cl_out2),
    .result(result2), .done(done2)
  );
  assign cl_out2 = cl_eval(cl_a2, cl_b2, cl_s2);

  cl_serial_drv #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op_in(op32), .a_in(a32), .b_in(b32),
    .ready(ready32), .cl_a(cl_a32), .cl_b(cl_b32), .cl_s(cl_s32), .cl_out(cl_out32),
    .result(result32), .done(done32)
  );
  assign cl_out32 = cl_eval(cl_a32, cl_b32, cl_s32);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_word(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    case (op)
      OP_AND:  ref_word = a & b;
      OP_OR:   ref_word = a | b;
      OP_XOR:  ref_word = a ^ b;
      default: ref_word = ~a;
    endcase
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [7:0] exp, input string tag);
    a_in = a; b_in = b; op_in = op; start = 1'b1;
    tick();
    start = 1'b0; a_in = 8'h00; b_in = 8'h00; op_in = 2'b00;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_cl_a"}, cl_a, a[i]);
      check({tag, "_cl_b"}, cl_b, b[i]);
      check({tag, "_busy_done"}, done, 1'b0);
      check({tag, "_busy_ready"}, ready, 1'b0);
      tick();
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_result"}, result, exp);
    check({tag, "_cl_s"}, cl_s, op);
    tick();
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_ready"}, ready, 1'b1);
    check({tag, "_hold_result"}, result, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_in = 2'b00; a_in = 8'h00; b_in = 8'h00;
    start2 = 1'b0; op2 = 2'b00; a2 = 2'b00; b2 = 2'b00;
    start32 = 1'b0; op32 = 2'b00; a32 = 32'h0; b32 = 32'h0;
    tick(); tick();
    reset = 1'b0;

    // reset state held while idle
    for (int i = 0; i < 5; i++) begin
      check("rst_ready", ready, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 8'h00);
      check("rst_cl_a", cl_a, 1'b0);
      check("rst_cl_b", cl_b, 1'b0);
      check("rst_cl_s", cl_s, 2'b00);
      tick();
    end

    do_op(8'hCA, 8'h0F, OP_AND, 8'h0A, "and_ca_0f");

    // back-to-back: start held high through DONE
    a_in = 8'h12; b_in = 8'h34; op_in = OP_OR; start = 1'b1;
    tick();
    a_in = 8'hF0; b_in = 8'h3C; op_in = OP_XOR;
    for (int i = 0; i < 8; i++) begin
      check("b2b_first_busy", done, 1'b0);
      tick();
    end
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_result", result, 8'h36);
    check("b2b_first_ready", ready, 1'b1);
    tick();
    check("b2b_second_cl_s", cl_s, OP_XOR);
    for (int i = 0; i < 8; i++) begin
      check("b2b_second_busy", done, 1'b0);
      check("b2b_second_ready", ready, 1'b0);
      tick();
    end
    start = 1'b0;
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_result", result, 8'hCC);
    tick();
    check("b2b_after_done", done, 1'b0);

    // start pulses during SHIFT are ignored
    a_in = 8'h0F; b_in = 8'hFF; op_in = OP_AND; start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      start = (i == 2 || i == 4);
      a_in = 8'hA5 + 8'(i); b_in = 8'h5A; op_in = OP_XOR;
      check("ign_ready", ready, 1'b0);
      check("ign_busy_done", done, 1'b0);
      tick();
    end
    start = 1'b0;
    check("ign_done", done, 1'b1);
    check("ign_result", result, 8'h0F);
    tick();
    check("ign_single_done_a", done, 1'b0);
    tick();
    check("ign_single_done_b", done, 1'b0);

    // reset mid-operation abandons it
    a_in = 8'h55; b_in = 8'hAA; op_in = OP_OR; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", ready, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 8'h00);
    check("midrst_cl_s", cl_s, 2'b00);
    check("midrst_cl_a", cl_a, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("midrst_no_done", done, 1'b0);
      tick();
    end
    do_op(8'h55, 8'hAA, OP_OR, 8'hFF, "or_55_aa");

    // sweep every op over all 2-bit (a,b) patterns replicated across the word
    for (int op = 0; op < 4; op++) begin
      for (int ab = 0; ab < 16; ab++) begin
        logic [1:0] pa, pb;
        logic [7:0] wa, wb;
        pa = 2'(ab); pb = 2'(ab >> 2);
        wa = {4{pa}}; wb = {4{pb}};
        do_op(wa, wb, 2'(op), ref_word(wa, wb, 2'(op)), "sweep");
      end
    end

    // WIDTH=2 latency
    a2 = 2'b10; b2 = 2'b11; op2 = OP_XOR; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 40) begin
      tick();
      n++;
    end
    check("w2_latency", n, 3);
    check("w2_result", result2, 2'b01);

    // WIDTH=32 latency
    a32 = 32'hDEADBEEF; b32 = 32'hFFFF0000; op32 = OP_AND; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    n = 1;
    while (!done32 && n < 60) begin
      tick();
      n++;
    end
    check("w32_latency", n, 33);
    check("w32_result", result32, 32'hDEAD0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
